mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side end of the processor's rw_mem/mem_io bus. Holds program/data bytes
//  and an internal pointer; serves one byte per dbg_clk read cycle and takes a
//  jump target on write cycles. Host preloads it via a valid/ready port, then
//  starts it. Sits outside the processor, on the other end of mem_io.
// PARAMETERS
//  DEPTH      256  bytes of storage; power of two, 2..256; AW = clog2(DEPTH)
//  RESET_PTR  0    pointer value loaded on prog_start (must be < DEPTH)
// PORTS
//  dbg_clk      in     1   single clock, all state changes on rising edge
//  rst          in     1   synchronous, active-high reset
//  rw_mem       in     1   from processor: 1 = processor drives mem_io, 0 = we drive
//  mem_io       inout  8   shared data bus
//  prog_valid   in     1   host load byte valid
//  prog_ready   out    1   high while in PROG state
//  prog_data    in     8   host load byte
//  prog_start   in     1   one-cycle pulse: leave PROG, enter RUN
//  running      out    1   high in RUN
//  fault        out    1   sticky: out-of-range jump target seen
//  fetch_count  out    16  read cycles served in RUN, saturating
// BEHAVIOUR
//  Reset (rst=1 at edge): state=PROG, load_ptr=0, ptr=RESET_PTR, running=0,
//   fault=0, fetch_count=0; mem_io Z; storage contents NOT cleared.
//  States: PROG -> RUN (prog_start) ; RUN -> FAULT (bad jump) ; any -> PROG (rst).
//  prog_ready, running, mem_io enable: combinational decode of state (no extra lag).
//  PROG: mem_io Z, rw_mem ignored. prog_valid&prog_ready: mem[load_ptr]<=prog_data,
//   load_ptr<=load_ptr+1 mod DEPTH (silent wrap, overwrites). prog_valid and
//   prog_start same edge: byte written first, then RUN; ptr<=RESET_PTR on entry.
//  RUN, rw_mem=0: mem_io = mem[ptr] combinationally (async read of registered ptr),
//   valid same cycle; at edge ptr<=ptr+1 mod DEPTH, fetch_count+=1 (hold at 0xFFFF).
//  RUN, rw_mem=1: mem_io Z same cycle (no contention: enable = RUN & !rw_mem).
//   At edge: if mem_io < DEPTH, ptr<=mem_io[AW-1:0]; next read returns mem[target].
//   Else: fault<=1, state<=FAULT, ptr unchanged. fetch_count unchanged.
//  rw_mem toggling every cycle is legal; each cycle is handled independently.
//  prog_valid/prog_start in RUN or FAULT: ignored.
//  FAULT: mem_io Z, running=0, prog_ready=0, fault=1; exit only by rst.
//  rst mid-RUN or mid-load: next cycle PROG, bus released; stored bytes retained.
//  Latency: read data 0 cycles after rw_mem=0; jump visible on next read cycle.
// TESTING
//  1 Load 0x11,0x22,0x33,0x44, pulse prog_start, 4 cycles rw_mem=0 -> mem_io
//    0x11,0x22,0x33,0x44 in order, fetch_count=4, running=1.
//  2 After test 1 state, rw_mem=1 with bench driving 0x02 -> DUT Z that cycle;
//    next rw_mem=0 cycle mem_io=0x33, fetch_count unchanged by the write cycle.
//  3 DEPTH=256, jump to 0xFF, mem[0xFF]=0xAB, mem[0]=0x11: two reads -> 0xAB then
//    0x11 (pointer wrap).
//  4 DEPTH=16, jump target 0x20 -> fault=1, running=0, mem_io Z; further
//    rw_mem=0 cycles leave mem_io Z, fetch_count frozen, until rst.
//  5 rst asserted mid-RUN -> next cycle prog_ready=1, mem_io Z, fetch_count=0;
//    prog_start then reads return previously loaded bytes unchanged.
//  6 prog_valid(0x5A)+prog_start same edge with load_ptr=0 -> running=1 and the
//    first read (RESET_PTR=0) returns 0x5A.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the rw_mem/mem_io bus: host preload in PROG, then serves
// one byte per read cycle and accepts pointer jumps on write cycles while in RUN.
module mem_responder #(
  parameter int DEPTH     = 256,
  parameter int RESET_PTR = 0
) (
  input  logic        dbg_clk,
  input  logic        rst,
  input  logic        rw_mem,
  inout  wire  [7:0]  mem_io,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic [7:0]  prog_data,
  input  logic        prog_start,
  output logic        running,
  output logic        fault,
  output logic [15:0] fetch_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_PROG,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t          state;
  logic [AW-1:0]   load_ptr;
  logic [AW-1:0]   ptr;
  logic [7:0]      mem [DEPTH];
  logic            drive_en;
  logic            jump_ok;

  // Status outputs and the bus enable decode straight from state so a read
  // cycle returns data in the same cycle rw_mem drops.
  assign prog_ready = (state == ST_PROG);
  assign running    = (state == ST_RUN);
  assign fault      = (state == ST_FAULT);
  assign drive_en   = running & ~rw_mem;
  assign mem_io     = drive_en ? mem[ptr] : 'z;

  // A jump target is legal only if it addresses existing storage.
  assign jump_ok = ({24'd0, mem_io} < 32'(DEPTH));

  // NOTE: storage has no reset so loaded bytes survive rst; only the write
  // enable is qualified, which also keeps it mappable onto plain RAM.
  always_ff @(posedge dbg_clk) begin
    if (!rst && prog_ready && prog_valid) begin
      mem[load_ptr] <= prog_data;
    end
  end

  always_ff @(posedge dbg_clk) begin
    if (rst) begin
      state       <= ST_PROG;
      load_ptr    <= '0;
      ptr         <= AW'(RESET_PTR);
      fetch_count <= '0;
    end else begin
      case (state)
        ST_PROG: begin
          if (prog_valid) begin
            load_ptr <= load_ptr + 1'b1;
          end
          if (prog_start) begin
            state <= ST_RUN;
            ptr   <= AW'(RESET_PTR);
          end
        end
        ST_RUN: begin
          if (!rw_mem) begin
            ptr <= ptr + 1'b1;
            if (fetch_count != 16'hFFFF) begin
              fetch_count <= fetch_count + 16'd1;
            end
          end else if (jump_ok) begin
            ptr <= mem_io[AW-1:0];
          end else begin
            state <= ST_FAULT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written jump/fault/wrap
// sequences, then random traffic checked against a behavioural model (DEPTH=256).
module tb_mem_responder;

  logic        dbg_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw_mem = 1'b0;
  logic [7:0]  drv_data = 8'h00;
  logic        prog_valid = 1'b0;
  logic [7:0]  prog_data = 8'h00;
  logic        prog_start = 1'b0;

  // Pulled-up buses: a released bus reads 0xFF.
  tri1 [7:0]   bus_b;
  tri1 [7:0]   bus_s;
  assign bus_b = rw_mem ? drv_data : 8'hzz;
  assign bus_s = rw_mem ? drv_data : 8'hzz;

  logic        rdy_b, run_b, flt_b, rdy_s, run_s, flt_s;
  logic [15:0] cnt_b, cnt_s;

  always #5 dbg_clk = ~dbg_clk;

  mem_responder #(.DEPTH(256), .RESET_PTR(0)) u_big (
    .dbg_clk(dbg_clk), .rst(rst), .rw_mem(rw_mem), .mem_io(bus_b),
    .prog_valid(prog_valid), .prog_ready(rdy_b), .prog_data(prog_data),
    .prog_start(prog_start), .running(run_b), .fault(flt_b), .fetch_count(cnt_b)
  );

  mem_responder #(.DEPTH(16), .RESET_PTR(0)) u_small (
    .dbg_clk(dbg_clk), .rst(rst), .rw_mem(rw_mem), .mem_io(bus_s),
    .prog_valid(prog_valid), .prog_ready(rdy_s), .prog_data(prog_data),
    .prog_start(prog_start), .running(run_s), .fault(flt_s), .fetch_count(cnt_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model of the 256-byte instance: mode 0 = loading, 1 = serving, 2 = halted.
  logic [7:0] m_mem [256];
  int         m_mode = 0;
  int         m_lp   = 0;
  int         m_ptr  = 0;
  int         m_cnt  = 0;
  bit         model_on = 1'b0;

  function automatic logic [7:0] model_bus();
    if (m_mode == 1 && !rw_mem) return m_mem[m_ptr];
    if (rw_mem) return drv_data;
    return 8'hFF;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_lp = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (prog_valid) begin
        m_mem[m_lp] = prog_data;
        m_lp = (m_lp + 1) % 256;
      end
      if (prog_start) begin
        m_mode = 1; m_ptr = 0;
      end
    end else if (m_mode == 1) begin
      if (!rw_mem) begin
        m_ptr = (m_ptr + 1) % 256;
        if (m_cnt < 65535) m_cnt++;
      end else if (int'(drv_data) < 256) begin
        m_ptr = int'(drv_data);
      end else begin
        m_mode = 2;
      end
    end
  endtask

  task automatic apply(input bit r, input bit rw, input logic [7:0] dd,
                       input bit v, input logic [7:0] pd, input bit st);
    rst = r; rw_mem = rw; drv_data = dd; prog_valid = v; prog_data = pd; prog_start = st;
    #1;
  endtask

  task automatic finish_cycle();
    @(posedge dbg_clk);
    model_edge();
    @(negedge dbg_clk);
  endtask

  task automatic step(input bit r, input bit rw, input logic [7:0] dd,
                      input bit v, input logic [7:0] pd, input bit st);
    apply(r, rw, dd, v, pd, st);
    if (model_on) begin
      check("model_bus",     32'(bus_b), 32'(model_bus()));
      check("model_ready",   32'(rdy_b), 32'(m_mode == 0));
      check("model_running", 32'(run_b), 32'(m_mode == 1));
      check("model_fault",   32'(flt_b), 32'(m_mode == 2));
      check("model_count",   32'(cnt_b), 32'(m_cnt));
    end
    finish_cycle();
  endtask

  function automatic logic [7:0] pat(input int i);
    if (i == 255) return 8'hAB;
    return 8'((i * 3 + 17) & 8'h7F);
  endfunction

  typedef struct {
    bit         r, rw, v, st, chk;
    logic [7:0] dd, pd;
    bit         rdy, run;
    logic [15:0] cnt;
    logic [7:0] bus;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit rw, input logic [7:0] dd,
                              input bit v, input logic [7:0] pd, input bit st, input bit chk,
                              input bit rdy, input bit run, input logic [15:0] cnt,
                              input logic [7:0] bus);
    vec_t t;
    t.r = r; t.rw = rw; t.dd = dd; t.v = v; t.pd = pd; t.st = st; t.chk = chk;
    t.rdy = rdy; t.run = run; t.cnt = cnt; t.bus = bus;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    // Expected values are those seen during the row, before its clock edge.
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h11, 0, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h22, 0, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h33, 0, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h44, 0, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd0, 8'h11));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd1, 8'h22));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd2, 8'h33));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd3, 8'h44));
    tbl.push_back(mk(0, 1, 8'h02, 0, 8'h00, 0, 1, 0, 1, 16'd4, 8'h02));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd4, 8'h33));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd5, 8'h44));
    tbl.push_back(mk(1, 1, 8'h77, 0, 8'h00, 0, 1, 0, 1, 16'd6, 8'h77));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd0, 8'h11));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd1, 8'h22));
    tbl.push_back(mk(1, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd2, 8'h00));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h5A, 1, 1, 1, 0, 16'd0, 8'hFF));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd0, 8'h5A));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 16'd1, 8'h22));

    @(negedge dbg_clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].rw, tbl[i].dd, tbl[i].v, tbl[i].pd, tbl[i].st);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_bus", i),     32'(bus_b), 32'(tbl[i].bus));
        check($sformatf("vec%0d_ready", i),   32'(rdy_b), 32'(tbl[i].rdy));
        check($sformatf("vec%0d_running", i), 32'(run_b), 32'(tbl[i].run));
        check($sformatf("vec%0d_fault", i),   32'(flt_b), 32'd0);
        check($sformatf("vec%0d_count", i),   32'(cnt_b), 32'(tbl[i].cnt));
      end
      finish_cycle();
    end

    // Full 256-byte load (load pointer wraps back to 0), then jump/fault/wrap cases.
    step(1, 1, 8'h00, 0, 8'h00, 0);
    model_on = 1'b1;
    for (int i = 0; i < 256; i++) step(0, 0, 8'h00, 1, pat(i), 0);
    step(0, 0, 8'h00, 0, 8'h00, 1);

    // The 16-byte instance kept only the last 16 bytes written.
    apply(0, 0, 8'h00, 0, 8'h00, 0);
    check("small_read0", 32'(bus_s), 32'(pat(240)));
    check("big_read0",   32'(bus_b), 32'h11);
    finish_cycle();
    step(0, 0, 8'h00, 0, 8'h00, 0);

    // 0x20 is out of range for DEPTH=16 only.
    apply(0, 1, 8'h20, 0, 8'h00, 0);
    check("small_jump_bus", 32'(bus_s), 32'h20);
    check("small_jump_running", 32'(run_s), 32'd1);
    finish_cycle();
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 8'h00, 0, 8'h00, 0);
      check($sformatf("small_fault%0d", k),   32'(flt_s), 32'd1);
      check($sformatf("small_running%0d", k), 32'(run_s), 32'd0);
      check($sformatf("small_ready%0d", k),   32'(rdy_s), 32'd0);
      check($sformatf("small_bus_z%0d", k),   32'(bus_s), 32'hFF);
      check($sformatf("small_count%0d", k),   32'(cnt_s), 32'd2);
      check($sformatf("big_after_jump%0d", k), 32'(bus_b), 32'(pat(32 + k)));
      finish_cycle();
    end

    // Jump to the last byte, then the pointer wraps to address 0.
    step(0, 1, 8'hFF, 0, 8'h00, 0);
    apply(0, 0, 8'h00, 0, 8'h00, 0);
    check("wrap_last", 32'(bus_b), 32'hAB);
    finish_cycle();
    apply(0, 0, 8'h00, 0, 8'h00, 0);
    check("wrap_first", 32'(bus_b), 32'h11);
    check("wrap_fault", 32'(flt_b), 32'd0);
    finish_cycle();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 50) == 0, 1'($urandom), 8'($urandom), 1'($urandom),
           8'($urandom), ($urandom % 8) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
